shared_resource_unit: RTL
=========================

Name: shared_resource_unit

Overview:
- Responder end of the pipeline valid/stall/flush interface: the shared resource that takes data from pipeline stage 3 and returns results to stage 4.
- Accepts 32-bit operands into a small input FIFO and multiplies each by a constant MULT using an iterative shift-add engine.
- Holds each result under downstream stall, back-pressures the pipeline when the FIFO is full, and discards all in-flight work on flush.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- MULT, 3, constant multiplier; must fit in MULT_BITS bits.
- MULT_BITS, 8, number of shift-add iterations, one per cycle.
- FIFO_DEPTH, 2, input FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data_from_pipeline  input  DATA_WIDTH  operand from pipeline.
- in_valid_from_pipeline  input  1  operand valid.
- in_flush_from_pipeline  input  1  flush request; sampled every cycle.
- in_stall_from_pipeline  input  1  downstream stall; result not taken this cycle.
- out_data_to_pipeline  output  DATA_WIDTH  result.
- out_valid_to_pipeline  output  1  result valid.
- out_flush_to_pipeline  output  1  registered flush echo.
- out_stall_to_pipeline  output  1  resource cannot accept an operand.

Behaviour:
- Reset (sync, active-high):
  - FIFO empty, FSM in IDLE, count 0.
  - out_data, out_valid and out_flush are 0 in the cycle after the reset edge.
  - out_stall = 0 after reset.
  - Reset mid-operation drops all work.
- Input handshake:
  - Operand accepted at the edge where in_valid=1 and out_stall_to_pipeline=0 and in_flush=0.
  - out_stall_to_pipeline = FIFO full. It is combinational from registered occupancy, with no dependence on in_valid.
- FIFO:
  - Push and pop in the same cycle leaves occupancy unchanged.
  - No push occurs when full, since stall is high.
  - Pop occurs only in IDLE when non-empty.
  - Strict FIFO order.
- FSM states: IDLE, COMPUTE, HOLD.
  - IDLE: if FIFO non-empty, pop head. Load mcand=head, mplier=MULT, acc=0, iter=MULT_BITS. Go to COMPUTE. Otherwise stay in IDLE.
  - COMPUTE: each cycle, if mplier[0] then acc=acc+mcand. Then mcand<<=1, mplier>>=1, iter-=1.
  - COMPUTE to HOLD: on the final iteration (iter==1), register acc+partial into out_data, set out_valid=1, go to HOLD.
  - HOLD: out_data and out_valid stay stable while in_stall_from_pipeline=1. At the edge where in_stall=0, the transfer completes: out_valid←0, go to IDLE.
- Arithmetic: all sums are modulo 2^DATA_WIDTH; overflow is truncated, not flagged.
- Latency:
  - Operand accepted at edge of cycle 0, FSM IDLE with empty FIFO: out_valid high in cycle MULT_BITS+2 (cycle 10 at defaults).
  - Minimum spacing between results is MULT_BITS+2 cycles.
- Flush:
  - in_flush=1 at an edge: FIFO cleared, FSM to IDLE, out_valid←0.
  - Flush takes priority over accept, pop, compute and transfer. An operand presented in the flush cycle is dropped.
  - out_flush_to_pipeline = in_flush delayed one cycle; a single-cycle pulse per flush cycle.
  - Flush during HOLD discards the held result.
- Simultaneous events:
  - Reset beats flush.
  - In HOLD with the FIFO non-empty, the next pop occurs in the IDLE cycle after the transfer, never in the same cycle.
- out_data is unchanged when out_valid=0, except at reset (0).

Test Plan:
1. Reset, then operand 7 accepted in cycle 0 with no stall (defaults) -> out_valid=1 in cycle 10 only, out_data=21; out_stall stays 0.
2. Operand 0xFFFFFFFF -> out_data=0xFFFFFFFD (truncated ×3); operand 0 -> out_data=0 with the same latency.
3. Hold result 21 with in_stall_from_pipeline high for 5 cycles -> out_data=21 and out_valid=1 stable for all 5 cycles plus the release cycle, then out_valid=0.
4. Operands 1,2,3,4 on back-to-back cycles:
   - out_stall rises when 2 entries are held, and only rises when the FIFO is full.
   - Results 3,6,9,12 come out in order, spaced ≥10 cycles apart.
   - No operand is lost or duplicated.
5. Flush in cycle 4 of computing operand 7, with one operand queued:
   - No result is produced and the FIFO is empty.
   - out_flush=1 in cycle 5 only.
   - Operand 5 sent afterwards -> 15 after 10 cycles.
6. Edge cases:
   - in_valid and in_flush high together -> operand dropped, no output.
   - Reset asserted during HOLD -> out_valid=0 and out_stall=0 next cycle.

Source files
------------

// File: rtl/shared_resource_unit.sv
// Shared multiply-by-constant resource on the pipeline valid/stall/flush interface.
// Operands queue in a small FIFO and are multiplied by MULT with an iterative shift-add engine.
module shared_resource_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MULT       = 3,
  parameter int MULT_BITS  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data_from_pipeline,
  input  logic                  in_valid_from_pipeline,
  input  logic                  in_flush_from_pipeline,
  input  logic                  in_stall_from_pipeline,
  output logic [DATA_WIDTH-1:0] out_data_to_pipeline,
  output logic                  out_valid_to_pipeline,
  output logic                  out_flush_to_pipeline,
  output logic                  out_stall_to_pipeline
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MULT_BITS + 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_e;

  state_e                                 state_q, state_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;
  logic [AW-1:0]                          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                          count_q, count_d;
  logic [DATA_WIDTH-1:0]                  mcand_q, mcand_d, acc_q, acc_d;
  logic [MULT_BITS-1:0]                   mplier_q, mplier_d;
  logic [IW-1:0]                          iter_q, iter_d;
  logic [DATA_WIDTH-1:0]                  out_data_q, out_data_d;
  logic                                   out_valid_q, out_valid_d;
  logic                                   out_flush_q, out_flush_d;

  logic                  full, push, pop;
  logic [DATA_WIDTH-1:0] partial;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = in_valid_from_pipeline && !full && !in_flush_from_pipeline;
  assign pop     = (state_q == IDLE) && (count_q != '0) && !in_flush_from_pipeline;
  assign partial = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    iter_d      = iter_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_flush_d = in_flush_from_pipeline;

    if (in_flush_from_pipeline) begin
      // Flush wins over everything; out_data keeps its last value.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data_from_pipeline;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);

      case (state_q)
        IDLE: begin
          if (pop) begin
            mcand_d  = mem_q[rd_ptr_q];
            mplier_d = MULT_BITS'(MULT);
            acc_d    = '0;
            iter_d   = IW'(MULT_BITS);
            state_d  = COMPUTE;
          end
        end
        COMPUTE: begin
          if (iter_q == IW'(1)) begin
            out_data_d  = acc_q + partial;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            iter_d   = iter_q - 1'b1;
          end
        end
        HOLD: begin
          // Transfer completes on a non-stalled edge; next pop waits for IDLE.
          if (!in_stall_from_pipeline) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      iter_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      iter_q      <= iter_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_flush_q <= out_flush_d;
    end
  end

  assign out_data_to_pipeline  = out_data_q;
  assign out_valid_to_pipeline = out_valid_q;
  assign out_flush_to_pipeline = out_flush_q;
  assign out_stall_to_pipeline = full;

endmodule
